uart_rx_buffered: RTL and testbench

Buffered UART receiver: the receive-side counterpart of `uart_tx`. It samples an asynchronous 8N1 serial line, recovers bytes, and flags framing errors. Recovered bytes are queued in a small first-word-fall-through FIFO so the consumer can drain them with a ready/pop handshake instead of catching a one-cycle strobe. It sits between the board RX pin and the command/data consumer logic.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 67 ++++++
 rtl/uart_rx_buffered.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   rx_state_t     : receiver FSM state encoding
//   UART_DATA_BITS : data bits per frame
//   clog2()        : ceiling log2, used for counter and pointer widths
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // ceil(log2(value)); returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO.
//   i_Clock, i_Reset : clock, synchronous active-high reset
//   i_Push, i_Data   : write request and data
//   i_Pop            : read request; ignored while empty
//   o_Data           : head entry (valid while not empty)
//   o_Full, o_Empty  : occupancy flags
//   o_Count          : number of stored entries (0..DEPTH)
// A push while full is dropped unless a pop happens in the same cycle;
// the caller is responsible for flagging the dropped entry.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
)
(
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic                      i_Push,
   input  logic                      i_Pop,
   input  logic [WIDTH-1:0]          i_Data,
   output logic [WIDTH-1:0]          o_Data,
   output logic                      o_Full,
   output logic                      o_Empty,
   output logic [clog2(DEPTH):0]     o_Count
);

   localparam int PTR_W = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign o_Empty = (count == '0);
   assign o_Full  = (count == (PTR_W+1)'(DEPTH));
   assign o_Count = count;
   assign o_Data  = mem[rd_ptr];

   // A same-cycle pop frees the head slot, so a push into a full FIFO
   // lands in the slot being vacated (wr_ptr == rd_ptr when full).
   assign do_pop  = i_Pop & ~o_Empty;
   assign do_push = i_Push & (~o_Full | do_pop);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= i_Data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: UART receiver with a FWFT receive FIFO.
//   i_Clock      : system clock
//   i_Reset      : synchronous active-high reset
//   i_RX_Serial  : asynchronous serial input, idles high
//   i_RX_Rd      : pop the head byte (only acts while o_RX_DV=1)
//   o_RX_DV      : FIFO not empty, o_RX_Byte valid
//   o_RX_Byte    : oldest unread byte
//   o_RX_Active  : frame reception in progress
//   o_Frame_Err  : 1-cycle pulse, stop bit sampled low
//   o_Overrun    : 1-cycle pulse, received byte dropped (FIFO full)
//   o_Parity_Err : 1-cycle pulse, even parity mismatch (UART_RX_PARITY_EN only)
// Build option: define UART_RX_PARITY_EN for 8E1 frames; default is 8N1.
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 4
)
(
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_RX_Serial,
   input  logic       i_RX_Rd,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_Active,
   output logic       o_Frame_Err,
`ifdef UART_RX_PARITY_EN
   output logic       o_Parity_Err,
`endif
   output logic       o_Overrun
);

   localparam int CNT_W = clog2(CLKS_PER_BIT);
   localparam int IDX_W = clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

   // synchronizer
   logic rx_meta;
   logic rx_s;

   // FSM
   rx_state_t                 state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      push;
   logic                      frame_err_d, frame_err_q;
   logic                      overrun_d, overrun_q;
`ifdef UART_RX_PARITY_EN
   logic                      par_q, par_d;
   logic                      parity_err_d, parity_err_q;
`endif

   // FIFO
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [clog2(FIFO_DEPTH):0] fifo_count;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d        = par_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = START;
            end
         end
         // Re-check the start bit at its midpoint; a high line here was a glitch.
         START: begin
            if (cnt_q == HALF_CNT) begin
               if (!rx_s) begin
                  cnt_d   = '0;
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Counter is aligned to the start-bit midpoint, so each full bit
         // period lands on the middle of the next bit. LSB arrives first.
         DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
               if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         // A bad stop bit outranks a parity mismatch.
         STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (!rx_s) begin
                  frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if ((^shift_q) ^ par_q) begin
                  parity_err_d = 1'b1;
`endif
               end else begin
                  push = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Full implies not empty, so a same-cycle read always frees a slot.
   assign overrun_d = push & fifo_full & ~i_RX_Rd;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         rx_meta      <= 1'b1;
         rx_s         <= 1'b1;
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_meta      <= i_RX_Serial;
         rx_s         <= rx_meta;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Push  (push),
      .i_Pop   (i_RX_Rd),
      .i_Data  (shift_q),
      .o_Data  (o_RX_Byte),
      .o_Full  (fifo_full),
      .o_Empty (fifo_empty),
      .o_Count (fifo_count)
   );

   // Occupancy flags must agree with the count.
   always_ff @(posedge i_Clock) begin
      if (!i_Reset) assert (fifo_empty == (fifo_count == '0));
   end

   assign o_RX_DV      = ~fifo_empty;
   assign o_RX_Active  = (state_q != IDLE);
   assign o_Frame_Err  = frame_err_q;
   assign o_Overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign o_Parity_Err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered. Frames are serialised here,
// expected bytes go into a queue model of the receive FIFO, and a monitor
// compares every pop the DUT performs against the head of that queue.
module tb_uart_rx_buffered;

   localparam int CPB   = 217;
   localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   // Edge (counted from the cycle the start bit is driven) on which the
   // stop bit is judged: 2 sync + 1 idle exit, half a bit to the start
   // midpoint (inclusive), then one full period per remaining bit.
   localparam int PUSH_EDGE = 3 + (CPB - 1) / 2 + 1 + (NBITS - 1) * CPB;

   logic       i_Clock;
   logic       i_Reset;
   logic       i_RX_Serial;
   logic       i_RX_Rd;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_RX_Active;
   logic       o_Frame_Err;
   logic       o_Overrun;
`ifdef UART_RX_PARITY_EN
   logic       o_Parity_Err;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
   int exp_fe = 0, exp_ov = 0, exp_pe = 0;
   logic fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;

   uart_rx_buffered #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .i_Clock      (i_Clock),
      .i_Reset      (i_Reset),
      .i_RX_Serial  (i_RX_Serial),
      .i_RX_Rd      (i_RX_Rd),
      .o_RX_DV      (o_RX_DV),
      .o_RX_Byte    (o_RX_Byte),
      .o_RX_Active  (o_RX_Active),
      .o_Frame_Err  (o_Frame_Err),
`ifdef UART_RX_PARITY_EN
      .o_Parity_Err (o_Parity_Err),
`endif
      .o_Overrun    (o_Overrun)
   );

   initial i_Clock = 1'b0;
   always #5 i_Clock = ~i_Clock;

   initial begin
      #(90000 * 10);
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge i_Clock);
      #1;
   endtask

   // Monitor: checks every effective pop and the width of each error pulse.
   always @(negedge i_Clock) begin
      if (i_Reset) begin
         fe_prev = 1'b0;
         ov_prev = 1'b0;
         pe_prev = 1'b0;
      end else begin
         if (i_RX_Rd && o_RX_DV) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL pop_unexpected: got 0x%0h expected no data", o_RX_Byte);
            end else begin
               chk("rx_byte", o_RX_Byte, exp_q.pop_front());
            end
         end
         if (fe_prev) chk("frame_err_width", o_Frame_Err, 0);
         if (ov_prev) chk("overrun_width", o_Overrun, 0);
         if (o_Frame_Err) fe_cnt++;
         if (o_Overrun) ov_cnt++;
         fe_prev = o_Frame_Err;
         ov_prev = o_Overrun;
`ifdef UART_RX_PARITY_EN
         if (pe_prev) chk("parity_err_width", o_Parity_Err, 0);
         if (o_Parity_Err) pe_cnt++;
         pe_prev = o_Parity_Err;
`endif
      end
   end

   // Serialise one frame. pop_cyc >= 0 pulses i_RX_Rd on that cycle;
   // abort_cyc >= 0 resets the DUT there and abandons the frame.
   task automatic send_frame(input logic [7:0] data, input logic stop,
                             input logic par_flip, input int pop_cyc,
                             input int abort_cyc);
      logic [NBITS-1:0] bits;
      logic par_ok;
`ifdef UART_RX_PARITY_EN
      bits   = {stop, (^data) ^ par_flip, data, 1'b0};
      par_ok = !par_flip;
`else
      bits   = {stop, data, 1'b0};
      par_ok = 1'b1 | par_flip;
`endif
      for (int c = 0; c < NBITS * CPB; c++) begin
         if (c == abort_cyc) begin
            i_Reset     = 1'b1;
            i_RX_Serial = 1'b1;
            i_RX_Rd     = 1'b0;
            tick();
            tick();
            i_Reset = 1'b0;
            exp_q.delete();
            return;
         end
         i_RX_Serial = bits[c / CPB];
         i_RX_Rd     = (c == pop_cyc);
         tick();
      end
      i_RX_Serial = 1'b1;
      i_RX_Rd     = 1'b0;
      if (!stop) exp_fe++;
      else if (!par_ok) exp_pe++;
      else if (exp_q.size() == DEPTH) exp_ov++;
      else exp_q.push_back(data);
   endtask

   task automatic do_reads(input int n);
      for (int i = 0; i < n; i++) begin
         i_RX_Rd = 1'b1;
         tick();
      end
      i_RX_Rd = 1'b0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_dv"}, o_RX_DV, exp_q.size() != 0);
      if (exp_q.size() != 0) chk({tag, "_head"}, o_RX_Byte, exp_q[0]);
      chk({tag, "_frame_errs"}, fe_cnt, exp_fe);
      chk({tag, "_overruns"}, ov_cnt, exp_ov);
`ifdef UART_RX_PARITY_EN
      chk({tag, "_parity_errs"}, pe_cnt, exp_pe);
`endif
   endtask

   initial begin
      int k;
      logic [7:0] d;
      logic s, f;
      i_Reset     = 1'b1;
      i_RX_Serial = 1'b1;
      i_RX_Rd     = 1'b0;
      repeat (5) tick();
      chk("rst_dv", o_RX_DV, 0);
      chk("rst_byte", o_RX_Byte, 0);
      chk("rst_active", o_RX_Active, 0);
      chk("rst_frame_err", o_Frame_Err, 0);
      chk("rst_overrun", o_Overrun, 0);
      i_Reset = 1'b0;
      repeat (3) tick();

      // single byte
      send_frame(8'h3F, 1'b1, 1'b0, -1, -1);
      check_state("single");
      do_reads(1);
      check_state("single_drain");

      // glitch shorter than half a bit
      i_RX_Serial = 1'b0;
      repeat (10) tick();
      chk("glitch_active_rise", o_RX_Active, 1);
      repeat (40) tick();
      i_RX_Serial = 1'b1;
      k = 0;
      while (o_RX_Active && k < 110) begin
         tick();
         k++;
      end
      chk("glitch_active_drop", o_RX_Active, 0);
      repeat (CPB) tick();
      check_state("glitch");

      // framing error
      send_frame(8'hA5, 1'b0, 1'b0, -1, -1);
      repeat (5) tick();
      check_state("frame_err");

      // overrun: five back-to-back bytes, no reads
      for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 1'b0, -1, -1);
      check_state("overrun");

      // full with a pop on the push cycle
      send_frame(8'h55, 1'b1, 1'b0, PUSH_EDGE - 1, -1);
      check_state("full_pop");
      do_reads(4);
      check_state("full_pop_drain");

      // reset mid-frame flushes the FIFO and the partial byte
      send_frame(8'($urandom), 1'b1, 1'b0, -1, -1);
      send_frame(8'hC3, 1'b1, 1'b0, -1, 5 * CPB + CPB / 2);
      chk("midrst_dv", o_RX_DV, 0);
      chk("midrst_active", o_RX_Active, 0);
      repeat (3 * CPB) tick();
      send_frame(8'h81, 1'b1, 1'b0, -1, -1);
      check_state("after_reset");
      do_reads(1);
`ifdef UART_RX_PARITY_EN
      send_frame(8'h81, 1'b1, 1'b1, -1, -1);
      repeat (5) tick();
      check_state("parity");
`endif

      // randomized frames, reads and gaps
      for (int n = 0; n < 10; n++) begin
         d = 8'($urandom);
         s = ($urandom_range(0, 5) != 0);
         f = ($urandom_range(0, 5) == 0);
         send_frame(d, s, f, -1, -1);
         repeat (5) tick();
         check_state("random");
         do_reads($urandom_range(0, exp_q.size() + 1));
         repeat ($urandom_range(0, 50)) tick();
      end

      do_reads(exp_q.size());
      check_state("final");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
